psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Sits directly downstream of a fusion_unit column and consumes its 32-bit signed psum stream.
- Sums a configurable number of consecutive psums, which together form one output-channel dot product, in a wide accumulator.
- Requantizes each finished sum by arithmetic right shift plus saturation to the configured output bitwidth.
- Buffers the results in a small FIFO with a valid/ready handshake to the writeback stage.

Parameters:
- ACC_W, 40: internal accumulator width in bits (≥ 32 + log2 of max acc_len).
- DEPTH, 4: output FIFO depth in entries (power of 2, ≥ 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- clear  in  1  synchronous; discards the partial group in progress and keeps the FIFO contents.
- psum_in  in  32  signed partial sum from the fusion_unit.
- psum_valid  in  1  psum_in is valid.
- psum_ready  out  1  the block can accept psum_in this cycle.
- acc_len  in  8  number of psums per group; 0 is treated as 1.
- out_bitwidth  in  3  output format: 3'b100 = 8-bit, 3'b010 = 4-bit, 3'b001 = 2-bit, any other value = 32-bit.
- shift  in  5  arithmetic right-shift amount applied before saturation.
- out_data  out  32  signed result, sign-extended to 32 bits.
- out_sat  out  1  the head result was saturated.
- out_valid  out  1  FIFO is not empty.
- out_ready  in  1  downstream stage accepts the head entry.
- busy  out  1  a group is in progress or a result is pending.

Behaviour:
- Beat acceptance: a beat is accepted at a rising edge when psum_valid && psum_ready.
- FSM states: ACCUM, DRAIN. Reset state is ACCUM with acc = 0, cnt = 0, len_q = 1.
- On reset: FIFO empty, out_valid = 0, out_data = 0, out_sat = 0, psum_ready = 1, busy = 0.
- ACCUM, first beat of a group (cnt == 0):
  - latch len_q = max(acc_len, 1); acc_len is ignored for the rest of the group.
  - acc = sext(psum_in).
- ACCUM, later beats: acc += sext(psum_in); cnt increments.
- Last beat of a group (cnt == len_q - 1):
  - res_q = acc + psum_in (the value including that beat).
  - cnt and acc clear; go to DRAIN.
- DRAIN:
  - psum_ready = 0.
  - Compute p = res_q >>> shift (arithmetic).
  - Saturate p to [-2^(B-1), 2^(B-1)-1], where B = 8/4/2/32 per out_bitwidth; out_sat = 1 if clamping occurred.
  - Push {p, sat} into the FIFO when it is not full, or when it is full and a pop happens in the same cycle.
  - On push, return to ACCUM. Otherwise stay in DRAIN, holding res_q.
- Latency: last beat accepted at edge E0; FIFO written at E1; out_valid = 1 after E1 if the FIFO had space. Each group costs exactly one psum_ready bubble.
- psum_ready = (state == ACCUM). It must not depend on out_ready combinationally.
- FIFO:
  - out_data and out_sat are driven from the head entry; out_valid = !empty.
  - Pop occurs on out_valid && out_ready.
  - Pop on empty is ignored. Simultaneous push and pop at full is legal and keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- Output stability: while out_valid && !out_ready, out_data and out_sat stay stable.
- clear:
  - In ACCUM: zeroes acc and cnt.
  - In DRAIN: abandons res_q and returns to ACCUM.
  - A beat presented in the same cycle as clear is dropped.
  - The FIFO is untouched.
- Mid-operation reset: immediate, asynchronous return to the reset values; a partial group is lost.
- Output field selection: out_bitwidth and shift are sampled in DRAIN, i.e. the values present at push time apply.
- busy = (cnt != 0) || (state == DRAIN).

Decomposition:
- bitfusion_pkg holds constants shared with fusion_unit:
  - BW_8 = 3'b100, BW_4 = 3'b010, BW_2 = 3'b001.
  - typedef psum_t (logic signed [31:0]).
  - typedef acc_state_t (ACCUM, DRAIN).
- One sub-module: psum_fifo, a synchronous FIFO (parameters WIDTH, DEPTH) with full/empty flags and a same-cycle push+pop at full.
- The shift/saturate logic stays inline as a function in this block.

Test Plan:
- Plain accumulation: acc_len = 4, out_bitwidth = 3'b000, shift = 0, psums 21, 130, -16256, -18 back to back.
  - out_data = -16123, out_sat = 0, out_valid rises one edge after the 4th beat.
  - psum_ready is low for exactly one cycle.
- Saturation and shifting with acc_len = 1:
  - 1778, shift 2, 8-bit → out_data = 127, out_sat = 1.
  - -512, shift 3, 8-bit → out_data = -64, out_sat = 0.
  - 2048, shift 4, 4-bit → out_data = 7, out_sat = 1.
  - -1024, shift 8, 2-bit → out_data = -2, out_sat = 1.
- Backpressure: DEPTH = 4, out_ready = 0, acc_len = 1, psums 1..6.
  - Entries 1..4 are stored; value 5 is held in DRAIN with psum_ready = 0; value 6 is not accepted.
  - Raise out_ready: pops 1, 2, 3, 4, 5, 6 in order; no loss, no duplication.
- acc_len change mid-group and acc_len = 0:
  - Start a group with acc_len = 3 and switch to 5 after the first beat; the result is the sum of 3 beats.
  - acc_len = 0 with psum 9 → out_data = 9.
- clear and reset mid-group:
  - With acc_len = 4, after 2 beats (10, 20) assert clear, then send 4 beats of 1 → out_data = 4; the FIFO entries present before clear are still delivered first.
  - Assert RST asynchronously mid-group → out_valid = 0, psum_ready = 1, busy = 0 immediately.

Source files
------------

// File: rtl/bitfusion_pkg.sv
// Constants and types shared between the fusion_unit column and its psum consumers.
package bitfusion_pkg;

    localparam logic [2:0] BW_8 = 3'b100;
    localparam logic [2:0] BW_4 = 3'b010;
    localparam logic [2:0] BW_2 = 3'b001;

    typedef logic signed [31:0] psum_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO; a push is still taken at full when a pop happens in the same cycle.
module psum_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Sums groups of psums, requantizes each group result (shift + saturate) and queues it for writeback.
module psum_accumulator
    import bitfusion_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        clear,
    input  logic [31:0] psum_in,
    input  logic        psum_valid,
    output logic        psum_ready,
    input  logic [7:0]  acc_len,
    input  logic [2:0]  out_bitwidth,
    input  logic [4:0]  shift,
    output logic [31:0] out_data,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    // Returns {sat, value[31:0]}; the clamp bounds follow the selected output width.
    function automatic logic [32:0] requant(input logic signed [ACC_W-1:0] val,
                                            input logic [4:0] sh,
                                            input logic [2:0] bw);
        logic signed [ACC_W-1:0] p;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        logic [4:0]              msb;
        logic                    sat;
        p   = val >>> sh;
        sat = 1'b0;
        case (bw)
            BW_8:    msb = 5'd7;
            BW_4:    msb = 5'd3;
            BW_2:    msb = 5'd1;
            default: msb = 5'd31;
        endcase
        hi = (ACC_W'(1) << msb) - ACC_W'(1);
        lo = ~hi;
        if (p > hi) begin
            p   = hi;
            sat = 1'b1;
        end else if (p < lo) begin
            p   = lo;
            sat = 1'b1;
        end
        return {sat, p[31:0]};
    endfunction

    acc_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] res_q;
    logic [7:0]              cnt;
    logic [7:0]              len_q;

    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] sum;
    logic [7:0]              len_eff;
    logic                    accept;
    logic                    last;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [32:0]             rq;
    logic [32:0]             head;

    assign psum_ready = (state == ACCUM);
    assign busy       = (cnt != 8'd0) || (state == DRAIN);

    assign psum_ext = {{(ACC_W-32){psum_in[31]}}, psum_in};
    assign accept   = psum_valid && psum_ready;
    // The group length is captured on the first beat, so acc_len changes mid-group are ignored.
    assign len_eff  = (cnt == 8'd0) ? ((acc_len == 8'd0) ? 8'd1 : acc_len) : len_q;
    assign last     = (cnt == len_eff - 8'd1);
    assign sum      = (cnt == 8'd0) ? psum_ext : acc + psum_ext;

    assign rq   = requant(res_q, shift, out_bitwidth);
    assign pop  = out_valid && out_ready;
    assign push = (state == DRAIN) && !clear && (!fifo_full || pop);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            len_q <= 8'd1;
            res_q <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        if (cnt == 8'd0) len_q <= len_eff;
                        if (last) begin
                            res_q <= sum;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (clear || push) state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    psum_fifo #(
        .WIDTH(33),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (push),
        .wdata (rq),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[31:0];
    assign out_sat   = head[32];

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: accumulation, requantization, backpressure, clear and reset.
module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               RST = 1'b1;
    logic               clear = 1'b0;
    logic signed [31:0] psum_in = '0;
    logic               psum_valid = 1'b0;
    logic               psum_ready;
    logic [7:0]         acc_len = 8'd1;
    logic [2:0]         out_bitwidth = 3'b000;
    logic [4:0]         shift = 5'd0;
    logic signed [31:0] out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;

    int n_vec = 0;
    int n_mis = 0;
    int got[$];
    logic acc_now;
    logic pop_now;
    logic signed [31:0] snap;

    psum_accumulator dut (
        .clk          (clk),
        .RST          (RST),
        .clear        (clear),
        .psum_in      (psum_in),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .acc_len      (acc_len),
        .out_bitwidth (out_bitwidth),
        .shift        (shift),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one beat at a negedge and returns at the negedge after it is accepted.
    task automatic send(input int v);
        int n;
        n = 0;
        psum_valid = 1'b1;
        psum_in    = v;
        while (!psum_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", longint'(psum_ready), 1);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input int exp_d, input int exp_s);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, longint'(out_valid), 1);
        check({tag, "_data"}, longint'(out_data), longint'(exp_d));
        check({tag, "_sat"}, longint'(out_sat), longint'(exp_s));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_ov", longint'(out_valid), 0);
        check("rst_rdy", longint'(psum_ready), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_data", longint'(out_data), 0);
        check("rst_sat", longint'(out_sat), 0);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);

        // Plain accumulation, one bubble per group
        acc_len = 8'd4; out_bitwidth = 3'b000; shift = 5'd0;
        send(21); send(130); send(-16256); send(-18);
        check("t1_bubble", longint'(psum_ready), 0);
        check("t1_ov_e0", longint'(out_valid), 0);
        check("t1_busy", longint'(busy), 1);
        @(negedge clk);
        check("t1_rdy_back", longint'(psum_ready), 1);
        check("t1_ov_e1", longint'(out_valid), 1);
        pop_expect("t1", -16123, 0);

        // Shift and saturation, one psum per group
        acc_len = 8'd1;
        shift = 5'd2; out_bitwidth = 3'b100; send(1778);  pop_expect("sat8", 127, 1);
        shift = 5'd3; out_bitwidth = 3'b100; send(-512);  pop_expect("shr8", -64, 0);
        shift = 5'd4; out_bitwidth = 3'b010; send(2048);  pop_expect("sat4", 7, 1);
        shift = 5'd8; out_bitwidth = 3'b001; send(-1024); pop_expect("sat2", -2, 1);
        shift = 5'd0; out_bitwidth = 3'b000;

        // Backpressure with a full FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(i);
        psum_valid = 1'b1; psum_in = 6;
        repeat (4) @(negedge clk);
        check("bp_rdy_low", longint'(psum_ready), 0);
        check("bp_busy", longint'(busy), 1);
        check("bp_head", longint'(out_data), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            acc_now = psum_valid && psum_ready;
            pop_now = out_valid && out_ready;
            snap    = out_data;
            @(posedge clk);
            @(negedge clk);
            if (acc_now) psum_valid = 1'b0;
            if (pop_now) got.push_back(int'(snap));
        end
        out_ready = 1'b0;
        check("bp_count", longint'(got.size()), 6);
        for (int i = 0; i < got.size() && i < 6; i++) check("bp_order", longint'(got[i]), longint'(i + 1));

        // acc_len change mid-group, then acc_len = 0
        acc_len = 8'd3; send(100);
        acc_len = 8'd5; send(200); send(300);
        pop_expect("len_latch", 600, 0);
        check("len_idle", longint'(busy), 0);
        acc_len = 8'd0; send(9);
        pop_expect("len_zero", 9, 0);

        // clear in ACCUM keeps earlier FIFO entries
        acc_len = 8'd1; send(77); send(88);
        acc_len = 8'd4; send(10); send(20);
        clear = 1'b1; psum_valid = 1'b1; psum_in = 999;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0; psum_valid = 1'b0;
        check("clr_busy", longint'(busy), 0);
        for (int i = 0; i < 4; i++) send(1);
        pop_expect("clr_old0", 77, 0);
        pop_expect("clr_old1", 88, 0);
        pop_expect("clr_new", 4, 0);

        // clear in DRAIN abandons the held result
        acc_len = 8'd1;
        for (int i = 11; i <= 15; i++) send(i);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("clrd_rdy", longint'(psum_ready), 1);
        check("clrd_busy", longint'(busy), 0);
        for (int i = 11; i <= 14; i++) pop_expect("clrd_pop", i, 0);
        check("clrd_empty", longint'(out_valid), 0);

        // Asynchronous reset mid-group
        send(3);
        acc_len = 8'd4; send(5); send(6);
        #2 RST = 1'b1;
        #1;
        check("arst_ov", longint'(out_valid), 0);
        check("arst_rdy", longint'(psum_ready), 1);
        check("arst_busy", longint'(busy), 0);
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(2);
        pop_expect("arst_after", 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
